execute_md: RTL and testbench

- Parametrised successor to the current RV32I execute stage; sits between the ID/EX and EX/MEM pipeline registers.
- Adds configurable XLEN and forwarding-source count, plus an RV32M/RV64M multiply/divide path.
- The divider is iterative and multi-cycle and raises `busy` to stall upstream stages.
- Branch/jump resolution, misaligned-target detection and the EX/MEM pipeline register are integrated.

---
 rtl/execute_md.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_execute_md.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_md.sv
// RV32/64 execute stage with operand forwarding, branch resolution, single-cycle
// multiplier, iterative restoring divider and the EX/MEM register.
module execute_md #(
    parameter int XLEN   = 32,
    parameter int NFWD   = 4,
    parameter int MUL_EN = 1,
    parameter int DIV_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   keep,
    input  logic                   nop,
    input  logic                   in_valid,
    input  logic [XLEN-1:0]        pc,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic [XLEN-1:0]        imm,
    input  logic [4:0]             wreg,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic [NFWD-1:0]        fwd_rs1,
    input  logic [NFWD-1:0]        fwd_rs2,
    input  logic [3:0]             alu_ctrl,
    input  logic [2:0]             alu_src,
    input  logic                   md_op,
    input  logic [2:0]             funct3,
    input  logic [2:0]             branch,
    output logic                   busy,
    output logic                   out_valid,
    output logic [XLEN-1:0]        result,
    output logic [XLEN-1:0]        store_data,
    output logic [4:0]             wreg_out,
    output logic [2:0]             funct3_out,
    output logic                   br_taken,
    output logic [XLEN-1:0]        br_target,
    output logic                   exc_misalign,
    output logic                   exc_illegal
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(XLEN + 1);
    localparam int PW = 2 * XLEN + 2;
    localparam logic [XLEN-1:0] LSB  = XLEN'(1);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR  = 4'd3,
                           A_XOR = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                           A_SLT = 4'd8, A_SLTU = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q;
    logic [XLEN-1:0]        rem_q, quo_q, dvs_q;
    logic                   negq_q, negr_q, selrem_q;
    logic [4:0]             dwreg_q;
    logic [2:0]             df3_q;

    logic                   valid_q, brt_q, mis_q, ill_q;
    logic [XLEN-1:0]        result_q, store_q, tgt_q;
    logic [4:0]             wreg_q;
    logic [2:0]             f3_q;

    logic                   valid_d, brt_d, mis_d, ill_d;
    logic [XLEN-1:0]        result_d, store_d, tgt_d;
    logic [4:0]             wreg_d;
    logic [2:0]             f3_d;

    logic signed [XLEN-1:0] rs1_f, rs2_f, op_a, op_b, alu_res;
    logic [SW-1:0]          shamt;
    logic                   taken, is_jump, is_jalr, misalign, illegal;
    logic [XLEN-1:0]        jalr_sum, target, mul_res;
    logic signed [PW-1:0]   mul_a_w, mul_b_w, prod;
    logic                   mul_a_sgn, mul_b_sgn;

    logic                   div_start, div_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]        a_mag, b_mag, q_fix, r_fix, div_res;
    logic [XLEN:0]          shifted, diff;

    always_comb begin
        rs1_f = rs1_data;
        rs2_f = rs2_data;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_rs1[i]) rs1_f = fwd_data[i*XLEN +: XLEN];
            if (fwd_rs2[i]) rs2_f = fwd_data[i*XLEN +: XLEN];
        end
    end

    always_comb begin
        case (alu_src[2:1])
            2'b01:   op_a = rs1_f;
            2'b10:   op_a = pc;
            default: op_a = '0;
        endcase
        op_b  = alu_src[0] ? rs2_f : imm;
        shamt = op_b[SW-1:0];
        case (alu_ctrl)
            A_ADD:   alu_res = op_a + op_b;
            A_SUB:   alu_res = op_a - op_b;
            A_AND:   alu_res = op_a & op_b;
            A_OR:    alu_res = op_a | op_b;
            A_XOR:   alu_res = op_a ^ op_b;
            A_SLL:   alu_res = op_a << shamt;
            A_SRL:   alu_res = op_a >> shamt;
            A_SRA:   alu_res = op_a >>> shamt;
            A_SLT:   alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            A_SLTU:  alu_res = {{(XLEN-1){1'b0}}, ($unsigned(op_a) < $unsigned(op_b))};
            default: alu_res = '0;
        endcase
    end

    // JALR targets are realigned by the bit-0 mask and never flagged; pc-relative targets are checked.
    always_comb begin
        case (branch)
            3'b001:  taken = (rs1_f == rs2_f);
            3'b010:  taken = (rs1_f != rs2_f);
            3'b011:  taken = (rs1_f < rs2_f);
            3'b100:  taken = !(rs1_f < rs2_f);
            3'b101:  taken = ($unsigned(rs1_f) < $unsigned(rs2_f));
            3'b110:  taken = !($unsigned(rs1_f) < $unsigned(rs2_f));
            3'b111:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        is_jump  = (branch == 3'b111);
        is_jalr  = is_jump && alu_src[1];
        jalr_sum = rs1_f + imm;
        target   = is_jalr ? (jalr_sum & ~LSB) : (pc + imm);
        misalign = taken && !is_jalr && (target[1:0] != 2'b00);
    end

    always_comb begin
        mul_a_sgn = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
        mul_b_sgn = (funct3[1:0] == 2'b01);
        mul_a_w   = {{(XLEN+2){mul_a_sgn & rs1_f[XLEN-1]}}, rs1_f};
        mul_b_w   = {{(XLEN+2){mul_b_sgn & rs2_f[XLEN-1]}}, rs2_f};
        prod      = mul_a_w * mul_b_w;
        mul_res   = (funct3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        illegal   = md_op && (funct3[2] ? (DIV_EN == 0) : (MUL_EN == 0));
    end

    logic unused_prod_bits;
    assign unused_prod_bits = ^prod[PW-1:2*XLEN];

    always_comb begin
        div_start = in_valid && md_op && funct3[2] && (DIV_EN != 0);
        div_sgn   = !funct3[0];
        a_neg     = div_sgn & rs1_f[XLEN-1];
        b_neg     = div_sgn & rs2_f[XLEN-1];
        a_mag     = a_neg ? XLEN'(-rs1_f) : rs1_f;
        b_mag     = b_neg ? XLEN'(-rs2_f) : rs2_f;
        div_zero  = (rs2_f == '0);
        div_ovf   = div_sgn && (rs1_f == MINV) && (rs2_f == '1);
        shifted   = {rem_q, quo_q[XLEN-1]};
        diff      = shifted - {1'b0, dvs_q};
        q_fix     = negq_q ? -quo_q : quo_q;
        r_fix     = negr_q ? -rem_q : rem_q;
        div_res   = selrem_q ? r_fix : q_fix;
    end

    // Next EX/MEM slot: bubble unless an instruction completes this cycle
    always_comb begin
        valid_d  = 1'b0;
        result_d = '0;
        store_d  = '0;
        wreg_d   = '0;
        f3_d     = '0;
        brt_d    = 1'b0;
        tgt_d    = '0;
        mis_d    = 1'b0;
        ill_d    = 1'b0;
        if (!nop) begin
            if (state_q == S_IDLE && in_valid && !div_start) begin
                valid_d = 1'b1;
                store_d = rs2_f;
                f3_d    = funct3;
                if (illegal) begin
                    ill_d = 1'b1;
                end else if (md_op) begin
                    result_d = mul_res;
                    wreg_d   = wreg;
                end else if (misalign) begin
                    mis_d    = 1'b1;
                    result_d = pc;
                    tgt_d    = target;
                end else begin
                    result_d = is_jump ? (pc + XLEN'(4)) : alu_res;
                    wreg_d   = wreg;
                    brt_d    = taken;
                    tgt_d    = target;
                end
            end else if (state_q == S_FIX) begin
                valid_d  = 1'b1;
                result_d = div_res;
                wreg_d   = dwreg_q;
                f3_d     = df3_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            selrem_q <= 1'b0;
            dwreg_q  <= '0;
            df3_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            wreg_q   <= '0;
            f3_q     <= '0;
            brt_q    <= 1'b0;
            tgt_q    <= '0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else if (!keep) begin
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            wreg_q   <= wreg_d;
            f3_q     <= f3_d;
            brt_q    <= brt_d;
            tgt_q    <= tgt_d;
            mis_q    <= mis_d;
            ill_q    <= ill_d;
            if (nop) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (div_start) begin
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            selrem_q <= funct3[1];
                            dwreg_q  <= wreg;
                            df3_q    <= funct3;
                            if (div_zero) begin
                                quo_q   <= '1;
                                rem_q   <= rs1_f;
                                negq_q  <= 1'b0;
                                negr_q  <= 1'b0;
                                state_q <= S_FIX;
                            end else if (div_ovf) begin
                                quo_q   <= MINV;
                                rem_q   <= '0;
                                negq_q  <= 1'b0;
                                negr_q  <= 1'b0;
                                state_q <= S_FIX;
                            end else begin
                                quo_q   <= a_mag;
                                rem_q   <= '0;
                                dvs_q   <= b_mag;
                                negq_q  <= a_neg ^ b_neg;
                                negr_q  <= a_neg;
                                state_q <= S_DIV;
                            end
                        end
                    end
                    S_DIV: begin
                        if (!diff[XLEN]) begin
                            rem_q <= diff[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q <= shifted[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST) state_q <= S_FIX;
                    end
                    S_FIX: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy         = busy_q;
    assign out_valid    = valid_q;
    assign result       = result_q;
    assign store_data   = store_q;
    assign wreg_out     = wreg_q;
    assign funct3_out   = f3_q;
    assign br_taken     = brt_q;
    assign br_target    = tgt_q;
    assign exc_misalign = mis_q;
    assign exc_illegal  = ill_q;
endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: scoreboard of expected EX/MEM slots plus
// latency, stall, flush and reset checks on the divider.
module tb_execute_md;
    localparam int XLEN = 32;
    localparam int NFWD = 4;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_XOR = 4'd4, A_SRA = 4'd7,
                           A_SLT = 4'd8, A_SLTU = 4'd9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, keep, nop, in_valid, nd_in_valid, md_op;
    logic [XLEN-1:0]      pc, rs1_data, rs2_data, imm;
    logic [4:0]           wreg;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [NFWD-1:0]      fwd_rs1, fwd_rs2;
    logic [3:0]           alu_ctrl;
    logic [2:0]           alu_src, funct3, branch;

    logic            busy, out_valid, br_taken, exc_misalign, exc_illegal;
    logic [XLEN-1:0] result, store_data, br_target;
    logic [4:0]      wreg_out;
    logic [2:0]      funct3_out;

    logic            nd_busy, nd_out_valid, nd_br_taken, nd_exc_misalign, nd_exc_illegal;
    logic [XLEN-1:0] nd_result, nd_store_data, nd_br_target;
    logic [4:0]      nd_wreg_out;
    logic [2:0]      nd_funct3_out;

    execute_md #(.XLEN(XLEN), .NFWD(NFWD), .MUL_EN(1), .DIV_EN(1)) dut (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop), .in_valid(in_valid),
        .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .wreg(wreg),
        .fwd_data(fwd_data), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .alu_ctrl(alu_ctrl), .alu_src(alu_src), .md_op(md_op), .funct3(funct3),
        .branch(branch), .busy(busy), .out_valid(out_valid), .result(result),
        .store_data(store_data), .wreg_out(wreg_out), .funct3_out(funct3_out),
        .br_taken(br_taken), .br_target(br_target), .exc_misalign(exc_misalign),
        .exc_illegal(exc_illegal)
    );

    execute_md #(.XLEN(XLEN), .NFWD(NFWD), .MUL_EN(1), .DIV_EN(0)) u_nodiv (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop), .in_valid(nd_in_valid),
        .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .wreg(wreg),
        .fwd_data(fwd_data), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .alu_ctrl(alu_ctrl), .alu_src(alu_src), .md_op(md_op), .funct3(funct3),
        .branch(branch), .busy(nd_busy), .out_valid(nd_out_valid), .result(nd_result),
        .store_data(nd_store_data), .wreg_out(nd_wreg_out), .funct3_out(nd_funct3_out),
        .br_taken(nd_br_taken), .br_target(nd_br_target), .exc_misalign(nd_exc_misalign),
        .exc_illegal(nd_exc_illegal)
    );

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [4:0]  wreg;
        logic        bt;
        logic [31:0] tgt;
        logic        ct;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] res, input logic [4:0] w,
                        input logic bt, input logic [31:0] tgt, input logic ct,
                        input logic mis, input logic ill);
        exp_t e;
        e.tag = tag; e.res = res; e.wreg = w; e.bt = bt;
        e.tgt = tgt; e.ct = ct; e.mis = mis; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic collect();
        exp_t e;
        if (out_valid === 1'b1) begin
            chk1("sb_nonempty", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.tag, "_res"}, result, e.res);
                chk({e.tag, "_wreg"}, {27'd0, wreg_out}, {27'd0, e.wreg});
                chk1({e.tag, "_brt"}, br_taken, e.bt);
                if (e.ct) chk({e.tag, "_tgt"}, br_target, e.tgt);
                chk1({e.tag, "_mis"}, exc_misalign, e.mis);
                chk1({e.tag, "_ill"}, exc_illegal, e.ill);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        collect();
    endtask

    task automatic set_op(input logic [3:0] ac, input logic [2:0] as, input logic md,
                          input logic [2:0] f3, input logic [2:0] br, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                          input logic [4:0] w);
        in_valid = 1'b1; alu_ctrl = ac; alu_src = as; md_op = md; funct3 = f3;
        branch = br; pc = p; rs1_data = a; rs2_data = b; imm = im; wreg = w;
        fwd_rs1 = '0; fwd_rs2 = '0; fwd_data = '0;
    endtask

    task automatic wait_result(output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bsy++;
            tick();
            lat++;
        end
    endtask

    task automatic do_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat, bsy;
        set_op(A_ADD, 3'b011, 1'b1, f3, 3'b000, 32'h0, a, b, 32'h0, 5'd7);
        push(tag, exp_res, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk1({tag, "_busy_on"}, busy, 1'b1);
        wait_result(lat, bsy);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busycyc"}, 32'(bsy), 32'(exp_lat));
        chk1({tag, "_busy_off"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, bsy, nd_seen;
        rst = 1'b1; keep = 1'b0; nop = 1'b0; nd_in_valid = 1'b0;
        set_op(A_ADD, 3'b000, 1'b0, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_wreg", {27'd0, wreg_out}, 32'h0);
        chk1("rst_brt", br_taken, 1'b0);
        chk("rst_tgt", br_target, 32'h0);
        chk1("rst_mis", exc_misalign, 1'b0);
        chk1("rst_ill", exc_illegal, 1'b0);
        rst = 1'b0;
        tick();

        // forwarding priority and store data
        set_op(A_ADD, 3'b010, 1'b0, 3'b010, 3'b000, 32'h0, 32'd99, 32'd1, 32'd7, 5'd3);
        fwd_rs1 = 4'b0100; fwd_data[2*XLEN +: XLEN] = 32'd5;
        fwd_rs2 = 4'b0010; fwd_data[1*XLEN +: XLEN] = 32'h0000ABCD;
        push("add_fwd2", 32'd12, 5'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("store_fwd", store_data, 32'h0000ABCD);
        chk("f3_pass", {29'd0, funct3_out}, 32'd2);
        fwd_rs1 = 4'b0101; fwd_data[0 +: XLEN] = 32'd20;
        push("add_fwd0", 32'd27, 5'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk1("bubble", out_valid, 1'b0);

        // ALU
        set_op(A_SUB, 3'b011, 1'b0, 3'b000, 3'b000, 32'h0, 32'd5, 32'd9, 32'h0, 5'd4);
        push("sub", 32'hFFFFFFFC, 5'd4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        set_op(A_SRA, 3'b011, 1'b0, 3'b000, 3'b000, 32'h0, 32'h80000000, 32'd4, 32'h0, 5'd5);
        push("sra", 32'hF8000000, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        set_op(A_SLTU, 3'b011, 1'b0, 3'b000, 3'b000, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0, 5'd6);
        push("sltu", 32'd1, 5'd6, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        set_op(A_SLT, 3'b011, 1'b0, 3'b000, 3'b000, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0, 5'd6);
        push("slt", 32'd0, 5'd6, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        set_op(A_XOR, 3'b100, 1'b0, 3'b000, 3'b000, 32'h1000, 32'h0, 32'h0, 32'hFF, 5'd8);
        push("xor_pc", 32'h000010FF, 5'd8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // branches and jumps
        set_op(A_SUB, 3'b011, 1'b0, 3'b100, 3'b011, 32'h100, 32'hFFFFFFFD, 32'd2, 32'h20, 5'd0);
        push("blt", 32'hFFFFFFFB, 5'd0, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
        tick();
        set_op(A_SUB, 3'b011, 1'b0, 3'b101, 3'b100, 32'h100, 32'hFFFFFFFD, 32'd2, 32'h20, 5'd0);
        push("bge_nt", 32'hFFFFFFFB, 5'd0, 1'b0, 32'h120, 1'b1, 1'b0, 1'b0);
        tick();
        set_op(A_ADD, 3'b010, 1'b0, 3'b000, 3'b111, 32'h300, 32'h203, 32'h0, 32'h0, 5'd1);
        push("jalr", 32'h304, 5'd1, 1'b1, 32'h202, 1'b1, 1'b0, 1'b0);
        tick();
        set_op(A_ADD, 3'b100, 1'b0, 3'b000, 3'b111, 32'h102, 32'h0, 32'h0, 32'h20, 5'd1);
        push("jal_mis", 32'h102, 5'd0, 1'b0, 32'h122, 1'b1, 1'b1, 1'b0);
        tick();
        set_op(A_ADD, 3'b100, 1'b0, 3'b000, 3'b111, 32'h100, 32'h0, 32'h0, 32'h20, 5'd1);
        push("jal", 32'h104, 5'd1, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
        tick();

        // multiplier
        set_op(A_ADD, 3'b011, 1'b1, 3'b011, 3'b000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'd9);
        push("mulhu", 32'hFFFFFFFE, 5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        funct3 = 3'b001;
        push("mulh", 32'h0, 5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        funct3 = 3'b000;
        push("mul", 32'h1, 5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        funct3 = 3'b010; rs2_data = 32'd2;
        push("mulhsu", 32'hFFFFFFFF, 5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        funct3 = 3'b001; rs1_data = 32'h7FFFFFFF; rs2_data = 32'h7FFFFFFF;
        push("mulh_pos", 32'h3FFFFFFF, 5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();

        // divider
        do_div("div", 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
        do_div("rem", 3'b110, 32'd100, 32'hFFFFFFF9, 32'd2, 33);
        do_div("rem_neg", 3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);
        do_div("divu", 3'b101, 32'hFFFFFFFF, 32'd3, 32'h55555555, 33);
        do_div("remu", 3'b111, 32'hFFFFFFFF, 32'd10, 32'd5, 33);
        do_div("divu_z", 3'b101, 32'd7, 32'd0, 32'hFFFFFFFF, 1);
        do_div("remu_z", 3'b111, 32'd7, 32'd0, 32'd7, 1);
        do_div("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_div("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);

        // keep stretches the division by exactly the stalled cycles
        set_op(A_ADD, 3'b011, 1'b1, 3'b100, 3'b000, 32'h0, 32'd100, 32'hFFFFFFF9, 32'h0, 5'd7);
        push("div_keep", 32'hFFFFFFF2, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        keep = 1'b1;
        repeat (5) tick();
        chk1("keep_busy", busy, 1'b1);
        keep = 1'b0;
        wait_result(lat, bsy);
        chk("keep_lat", 32'(8 + lat), 32'd38);

        // nop aborts a division; nothing may complete afterwards
        set_op(A_ADD, 3'b011, 1'b1, 3'b100, 3'b000, 32'h0, 32'd100, 32'd7, 32'h0, 5'd7);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        nop = 1'b1;
        tick();
        nop = 1'b0;
        chk1("nop_busy", busy, 1'b0);
        chk1("nop_valid", out_valid, 1'b0);
        repeat (40) tick();

        // nop flushes a single-cycle op
        set_op(A_ADD, 3'b010, 1'b0, 3'b000, 3'b000, 32'h0, 32'd1, 32'd0, 32'd1, 5'd2);
        nop = 1'b1;
        tick();
        nop = 1'b0;
        in_valid = 1'b0;
        chk1("nop_flush", out_valid, 1'b0);
        chk("nop_flush_wreg", {27'd0, wreg_out}, 32'h0);

        // asynchronous reset mid-division
        set_op(A_ADD, 3'b011, 1'b1, 3'b100, 3'b000, 32'h0, 32'd100, 32'd7, 32'h0, 5'd7);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk1("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_valid", out_valid, 1'b0);
        chk("arst_result", result, 32'h0);
        #2;
        rst = 1'b0;
        repeat (3) tick();
        chk1("post_rst_busy", busy, 1'b0);

        // divider disabled: illegal op, never busy
        set_op(A_ADD, 3'b011, 1'b1, 3'b100, 3'b000, 32'h0, 32'd100, 32'd7, 32'h0, 5'd7);
        in_valid = 1'b0;
        nd_in_valid = 1'b1;
        tick();
        nd_in_valid = 1'b0;
        chk1("nd_ill", nd_exc_illegal, 1'b1);
        chk1("nd_valid", nd_out_valid, 1'b1);
        chk("nd_wreg", {27'd0, nd_wreg_out}, 32'h0);
        nd_seen = (nd_busy === 1'b1) ? 1 : 0;
        repeat (5) begin
            tick();
            if (nd_busy === 1'b1) nd_seen = 1;
        end
        chk("nd_busy_never", 32'(nd_seen), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
